// File: rtl/k_16_square.sv
// Sequential FP16 squarer: shift-add mantissa multiply, truncated result.
// Start/done handshake with one operation in flight.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operand and special-case flags latched
// MUL   | one shift-add step per cycle over mantissa bits i..10
// NORM  | normalise product, form exponent, register the result
// DONE  | done pulse with out valid; start ignored in this cycle
module k_16_square #(
  parameter int APPROX_LSBS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  localparam logic [3:0] IDX_FIRST = 4'(APPROX_LSBS);
  localparam logic [3:0] IDX_LAST  = 4'd10;

  state_t      state, state_nx;
  logic [10:0] a;
  logic [21:0] acc;
  logic [3:0]  idx;
  logic [4:0]  e_q;
  logic        zero_q, inf_q;
  logic [9:0]  mant_w;
  logic [6:0]  ex_w;
  logic [15:0] result_w;
  logic        sign_unused;

  // The square is always non-negative, so the operand sign is never needed.
  assign sign_unused = in[15];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; busy and done follow directly from the state.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = MUL;
      MUL: begin
        busy = 1'b1;
        if (idx == IDX_LAST) state_nx = NORM;
      end
      NORM: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Normalisation: a 1.x * 1.x product lies in [1,4); acc[21] selects the upper half.
  // Exponent is worked in 7 bits so underflow shows up as a negative value.
  always_comb begin
    mant_w = acc[21] ? acc[20:11] : acc[19:10];
    ex_w   = {1'b0, e_q, 1'b0} - 7'd15 + {6'd0, acc[21]};
    if (zero_q)                        result_w = 16'h0000;
    else if (inf_q)                    result_w = 16'h7C00;
    else if (!ex_w[6] && ex_w >= 7'd31) result_w = 16'h7BFF;
    else if (ex_w[6] || ex_w == 7'd0)  result_w = 16'h0000;
    else                               result_w = {1'b0, ex_w[4:0], mant_w};
  end

  // Operand capture, shift-add accumulation and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      acc    <= '0;
      idx    <= '0;
      e_q    <= '0;
      zero_q <= 1'b0;
      inf_q  <= 1'b0;
      out    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a      <= {1'b1, in[9:0]};
          acc    <= '0;
          idx    <= IDX_FIRST;
          e_q    <= in[14:10];
          zero_q <= (in[14:10] == 5'd0);
          inf_q  <= (in[14:10] == 5'd31);
        end
        MUL: begin
          if (a[idx]) acc <= acc + ({11'd0, a} << idx);
          idx <= idx + 4'd1;
        end
        NORM: out <= result_w;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_k_16_square.sv
// Bench for k_16_square: directed corner operands, handshake abuse,
// mid-operation reset and random operands against an arithmetic model.
module tb_k_16_square;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] in;
  logic        busy;
  logic        done;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  k_16_square dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  // Reference: exact integer square of the significand, then truncate.
  function automatic logic [15:0] model(input logic [15:0] v);
    int e, m, p, ex, mant;
    e = int'(v[14:10]);
    if (e == 0)  return 16'h0000;
    if (e == 31) return 16'h7C00;
    m = 1024 + int'(v[9:0]);
    p = m * m;
    if (p >= 2097152) begin
      ex   = 2 * e - 14;
      mant = (p >> 11) % 1024;
    end else begin
      ex   = 2 * e - 15;
      mant = (p >> 10) % 1024;
    end
    if (ex >= 31) return 16'h7BFF;
    if (ex <= 0)  return 16'h0000;
    return {1'b0, 5'(ex), 10'(mant)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge. With extra=1, start is re-asserted
  // in the 3rd and 12th cycle after acceptance; both must be ignored.
  task automatic run_op(input logic [15:0] v, input bit extra);
    int          k;
    int          n_done;
    bit          seen;
    logic [15:0] exp;
    exp   = model(v);
    start = 1'b1;
    in    = v;
    @(posedge clk); #1;
    start = 1'b0;
    in    = 16'($urandom);
    chk1("busy_accept", busy, 1'b1);
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 30) begin
      @(posedge clk); #1;
      k++;
      start = (extra && (k == 3 || k == 12));
      if (done) seen = 1'b1;
      else      chk1("busy_mid", busy, 1'b1);
    end
    chk("latency", 16'(k), 16'd12);
    chk(extra ? "result_extra" : "result", out, exp);
    chk1("busy_at_done", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    chk1("done_one_cycle", done, 1'b0);
    chk("out_hold", out, exp);
    if (extra) begin
      n_done = 0;
      for (int j = 0; j < 20; j++) begin
        @(posedge clk); #1;
        if (done) n_done++;
      end
      chk("extra_done_pulses", 16'(n_done), 16'd0);
      chk1("busy_after_ignored", busy, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in    = 16'h0000;
    #12;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk("reset_out", out, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h3C00, 1'b0);
    run_op(16'h3E00, 1'b0);
    run_op(16'hC000, 1'b0);
    run_op(16'h5C00, 1'b0);
    run_op(16'h1000, 1'b0);
    run_op(16'h7C00, 1'b0);
    run_op(16'h7E00, 1'b0);
    run_op(16'h0001, 1'b0);
    run_op(16'h3E00, 1'b1);

    // Abort in the middle of MUL; reset must act without a clock edge.
    start = 1'b1;
    in    = 16'h4A5A;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk("abort_out", out, 16'h0000);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h3E00, 1'b0);

    for (int r = 0; r < 40; r++) run_op(16'($urandom), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
